// File: rtl/stop_checker_if.sv
// ---------------------------------------------------------------------------
// stop_checker_if
//   Bundles the stop-bit check request and its status results.
//   The receive FSM / status side uses the master modport; the checker
//   uses the slave modport.
//
//   check_stop   : stop-bit sample-point strobe from the receive FSM
//   RX_data      : serial receive line (idle high)
//   stop_bit_err : registered framing-error flag (1 = stop bit sampled as 0)
//   stop_done    : one-cycle pulse, a check completed on the previous edge
//   err_count    : saturating framing-error count since reset
// ---------------------------------------------------------------------------
interface stop_checker_if #(
    parameter int WIDTH = 8
);
    logic             check_stop;
    logic             RX_data;
    logic             stop_bit_err;
    logic             stop_done;
    logic [WIDTH-1:0] err_count;

    modport master (
        output check_stop,
        output RX_data,
        input  stop_bit_err,
        input  stop_done,
        input  err_count
    );

    modport slave (
        input  check_stop,
        input  RX_data,
        output stop_bit_err,
        output stop_done,
        output err_count
    );
endinterface

// File: rtl/stop_checker.sv
// ---------------------------------------------------------------------------
// stop_checker
//   Stop-bit checker for the UART receiver datapath. When check_stop is
//   high the line is sampled; a low line is a framing error. Keeps a
//   registered error flag, a one-cycle done strobe and a saturating
//   framing-error counter. All outputs are registered.
//
//   Ports:
//     clk  : system clock, rising edge
//     rst  : synchronous, active-low reset
//     bus  : stop_checker_if.slave (check_stop, RX_data in;
//            stop_bit_err, stop_done, err_count out)
//
//   Optional feature (macro STOP_CHECKER_RX_SYNC_EN):
//     RX_data is passed through a 2-flop synchronizer (reset to idle/1)
//     before being sampled. The sampled value is then RX_data from two
//     cycles before the check edge; output latency stays one cycle.
// ---------------------------------------------------------------------------
module stop_checker #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    stop_checker_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t           state;
    logic             err_q;
    logic             done_q;
    logic [WIDTH-1:0] cnt_q;
    logic             s_rx;

`ifdef STOP_CHECKER_RX_SYNC_EN
    logic rx_meta;
    logic rx_sync;

    // Two-flop synchronizer; resets to the idle (mark) level so a reset
    // never looks like a start of a low line.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= bus.RX_data;
            rx_sync <= rx_meta;
        end
    end

    assign s_rx = rx_sync;
`else
    assign s_rx = bus.RX_data;
`endif

    // Control FSM plus the datapath registers. The state only drives the
    // done strobe; every check_stop cycle is an independent check, so
    // back-to-back strobes keep the FSM in DONE and update the flag and
    // counter each cycle. The error flag holds between checks so status
    // readers see the last result until the next check or reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            err_q  <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.check_stop) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (!bus.check_stop) begin
                        state  <= IDLE;
                        done_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
            endcase

            if (bus.check_stop) begin
                err_q <= ~s_rx;
                // Saturate at all-ones instead of wrapping back to zero.
                if (!s_rx && !(&cnt_q)) begin
                    cnt_q <= cnt_q + WIDTH'(1);
                end
            end
        end
    end

    assign bus.stop_bit_err = err_q;
    assign bus.stop_done    = done_q;
    assign bus.err_count    = cnt_q;

endmodule

// File: tb/tb_stop_checker.sv
// ---------------------------------------------------------------------------
// tb_stop_checker
//   Self-checking bench for stop_checker (WIDTH = 8). A table of per-cycle
//   vectors covers reset, a framing error with a held flag, and a good stop
//   bit; hand-written sequences cover back-to-back checks, synchronizer
//   delay (when STOP_CHECKER_RX_SYNC_EN is defined), counter saturation
//   and reset in the middle of operation.
// ---------------------------------------------------------------------------
module tb_stop_checker;

    localparam int WIDTH = 8;

`ifdef STOP_CHECKER_RX_SYNC_EN
    localparam int SYNC_DLY = 2;
`else
    localparam int SYNC_DLY = 0;
`endif

    logic clk;
    logic rst;

    stop_checker_if #(.WIDTH(WIDTH)) bus ();

    stop_checker #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10 time-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       chk;
        logic       rx;
        logic       e_err;
        logic       e_done;
        logic [7:0] e_cnt;
        string      name;
    } vec_t;

    vec_t vecs[$];

    int checks   = 0;
    int failures = 0;

    // Running expectations for the hand-written sequences.
    int   exp_cnt;
    logic exp_err;

    // Drive one cycle of inputs, then wait until just after the next
    // rising edge so outputs are sampled away from the edge.
    task automatic applyStimulus(input logic r, input logic c, input logic x);
        rst            = r;
        bus.check_stop = c;
        bus.RX_data    = x;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic e_err,
                               input logic e_done, input logic [7:0] e_cnt);
        checks++;
        if (bus.stop_bit_err !== e_err) begin
            failures++;
            $display("[TB] FAIL %s stop_bit_err got=%b expected=%b", name, bus.stop_bit_err, e_err);
        end
        checks++;
        if (bus.stop_done !== e_done) begin
            failures++;
            $display("[TB] FAIL %s stop_done got=%b expected=%b", name, bus.stop_done, e_done);
        end
        checks++;
        if (bus.err_count !== e_cnt) begin
            failures++;
            $display("[TB] FAIL %s err_count got=%0d expected=%0d", name, bus.err_count, e_cnt);
        end
    endtask

    initial begin
        logic pat [3];

        rst            = 1'b0;
        bus.check_stop = 1'b0;
        bus.RX_data    = 1'b1;

        // Per-cycle vectors. RX_data is held for at least three cycles
        // before any check whose sample differs, so the table holds with
        // or without the synchronizer.
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "reset_discards_check"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "idle_after_reset_0"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "idle_after_reset_1"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "idle_after_reset_2"});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1, "frame_err"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, "frame_err_hold_0"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, "frame_err_hold_1"});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, "frame_err_hold_2"});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, "frame_err_hold_3"});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, "frame_err_hold_4"});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1, "good_stop"});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, "good_stop_idle_0"});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, "good_stop_idle_1"});

        $display("[TB] applying %0d table vectors", vecs.size());
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].chk, vecs[i].rx);
            checkOutput(vecs[i].name, vecs[i].e_err, vecs[i].e_done, vecs[i].e_cnt);
        end

        exp_cnt = 1;
        exp_err = 1'b0;

        // Back-to-back: samples 0,1,0 on three consecutive check cycles.
        // RX_data is driven SYNC_DLY cycles ahead of the matching check.
        pat[0] = 1'b0;
        pat[1] = 1'b1;
        pat[2] = 1'b0;
        for (int i = 0; i < SYNC_DLY + 3; i++) begin
            logic x;
            x = (i < 3) ? pat[i] : 1'b1;
            applyStimulus(1'b1, (i >= SYNC_DLY), x);
            if (i >= SYNC_DLY) begin
                exp_err = ~pat[i - SYNC_DLY];
                if (pat[i - SYNC_DLY] == 1'b0) exp_cnt++;
                checkOutput("back_to_back", exp_err, 1'b1, 8'(exp_cnt));
            end else begin
                checkOutput("back_to_back_lead", exp_err, 1'b0, 8'(exp_cnt));
            end
        end
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("back_to_back_end", 1'b1, 1'b0, 8'd3);

`ifdef STOP_CHECKER_RX_SYNC_EN
        // A falling line is seen by the checker only on the third check.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
        end
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("sync_delay_0", 1'b0, 1'b1, 8'd3);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("sync_delay_1", 1'b0, 1'b1, 8'd3);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("sync_delay_2", 1'b1, 1'b1, 8'd4);
        exp_cnt = 4;
        applyStimulus(1'b1, 1'b0, 1'b0);
        exp_err = 1'b1;
`endif

        // Saturation: 260 consecutive failing checks.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 260; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            if (exp_cnt < 255) exp_cnt++;
            checkOutput("saturate", 1'b1, 1'b1, 8'(exp_cnt));
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            checkOutput("saturate_hold", 1'b1, 1'b0, 8'd255);
        end
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("saturate_good_stop", 1'b0, 1'b1, 8'd255);

        // Reset mid-operation, asserted while checks are still arriving.
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("mid_reset_prep", 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
        end
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            checkOutput("mid_reset_build", 1'b1, 1'b1, 8'(i));
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("mid_reset", 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("mid_reset_release", 1'b0, 1'b0, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
